// File: rtl/disp_y_ten_unit.sv
// Year-count display reader: sequential binary-to-BCD conversion (shift-add-3) feeding a
// two-digit multiplexed 7-segment driver with optional edit-mode blinking.
module disp_y_ten_unit #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25,
    parameter bit          ACT_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] value,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       conv_done
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0]  SEG_DASH = 7'h40;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t      state_q, state_d;
    logic [6:0]  val_q;
    logic        pending_q;
    logic [14:0] sr_q;
    logic [14:0] sr_step;
    logic [2:0]  cnt_q;
    logic [3:0]  tens_q, units_q;
    logic        oor_q;

    logic [SCAN_W-1:0]  scan_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               sel_q;
    logic               started_q;
    logic               phase_q;
    logic               scan_wrap;
    logic               blink_wrap;

    function automatic logic [14:0] dabble(input logic [14:0] s);
        logic [3:0]  t;
        logic [3:0]  u;
        logic [14:0] a;
        t = s[14:11];
        u = s[10:7];
        if (t >= 4'd5) t = t + 4'd3;
        if (u >= 4'd5) u = u + 4'd3;
        a = {t, u, s[6:0]};
        return {a[13:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign sr_step = dabble(sr_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pending_q || (value != val_q)) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (cnt_q == 3'd6) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // bcd_* and the dash flag load on the last shift so they change together, valid in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            val_q     <= 7'd0;
            pending_q <= 1'b1;
            sr_q      <= 15'd0;
            cnt_q     <= 3'd0;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            oor_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StLoad: begin
                    val_q     <= value;
                    sr_q      <= {8'd0, value};
                    pending_q <= 1'b0;
                    cnt_q     <= 3'd0;
                end
                StShift: begin
                    sr_q  <= sr_step;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd6) begin
                        tens_q  <= sr_step[14:11];
                        units_q <= sr_step[10:7];
                        oor_q   <= (val_q > 7'd99);
                    end
                end
                default: ;
            endcase
        end
    end

    assign conv_done = (state_q == StDone);
    assign bcd_tens  = tens_q;
    assign bcd_units = units_q;

    assign scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            sel_q       <= 1'b0;
            started_q   <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            if (scan_wrap) begin
                scan_cnt_q <= '0;
                sel_q      <= ~sel_q;
                started_q  <= 1'b1;
                if (blink_wrap) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                end
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
        end
    end

    logic       lit;
    logic [6:0] seg_on;
    logic [1:0] an_on;

    always_comb begin
        lit    = started_q && !(blink && phase_q);
        seg_on = 7'h00;
        an_on  = 2'b00;
        if (lit) begin
            an_on  = sel_q ? 2'b10 : 2'b01;
            seg_on = oor_q ? SEG_DASH : decode(sel_q ? tens_q : units_q);
        end
        seg = ACT_LOW ? ~seg_on : seg_on;
        an  = ACT_LOW ? ~an_on : an_on;
    end

endmodule

// File: tb/tb_disp_y_ten_unit.sv
// Directed self-checking bench for disp_y_ten_unit (SCAN_DIV=4, BLINK_DIV=2, active-low).
module tb_disp_y_ten_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] value;
    logic       blink;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       conv_done;

    int passed = 0;
    int total  = 0;

    disp_y_ten_unit #(
        .SCAN_DIV (4),
        .BLINK_DIV(2),
        .ACT_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .blink    (blink),
        .seg      (seg),
        .an       (an),
        .bcd_tens (bcd_tens),
        .bcd_units(bcd_units),
        .conv_done(conv_done)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] S_OFF  = 7'h7F;
    localparam logic [6:0] S_DASH = ~7'h40;
    localparam logic [6:0] S_0    = ~7'h3F;
    localparam logic [6:0] S_2    = ~7'h5B;
    localparam logic [6:0] S_3    = ~7'h4F;
    localparam logic [6:0] S_7    = ~7'h07;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns number of posedges until conv_done is seen at a negedge; 0 on timeout
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (conv_done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1; value = 7'd42; blink = 1'b0;
        step(); step();
        chk("reset_seg", {25'd0, seg}, {25'd0, S_OFF});
        chk("reset_an", {30'd0, an}, 32'h3);
        chk("reset_bcd", {24'd0, bcd_tens, bcd_units}, 32'h00);
        chk("reset_done", {31'd0, conv_done}, 32'd0);
        rst = 1'b0;
        wait_done(c);
        chk("first_conv_latency", c, 32'd9);
        chk("first_conv_bcd", {24'd0, bcd_tens, bcd_units}, 32'h42);
        step();
        chk("done_one_cycle", {31'd0, conv_done}, 32'd0);
    endtask

    task automatic test_sweep();
        int c;
        int bad = 0;
        for (int v = 0; v < 100; v++) begin
            value = 7'(v);
            wait_done(c);
            total++;
            if (c == 0 || bcd_tens !== 4'(v / 10) || bcd_units !== 4'(v % 10)) begin
                $display("FAIL sweep_%0d: got %0d/%0d expected %0d/%0d (cycles %0d)",
                         v, bcd_tens, bcd_units, v / 10, v % 10, c);
                bad++;
            end else begin
                passed++;
            end
        end
        chk("sweep_99", {24'd0, bcd_tens, bcd_units}, 32'h99);
    endtask

    task automatic test_scan();
        int c;
        int run;
        int changes = 0;
        logic [1:0] prev;
        value = 7'd37;
        wait_done(c);
        chk("scan_conv", {24'd0, bcd_tens, bcd_units}, 32'h37);
        step();
        prev = an;
        run = 0;
        for (int i = 0; i < 24; i++) begin
            if (an == 2'b10) chk("scan_units_seg", {25'd0, seg}, {25'd0, S_7});
            else if (an == 2'b01) chk("scan_tens_seg", {25'd0, seg}, {25'd0, S_3});
            else chk("scan_one_hot_an", {30'd0, an}, 32'h2);
            if (an == prev) begin
                run++;
            end else begin
                if (changes > 0) chk("scan_period", run, 32'd4);
                changes++;
                run = 1;
                prev = an;
            end
            step();
        end
        chk("scan_toggled", {31'd0, changes >= 4}, 32'd1);
    endtask

    task automatic test_mid_change();
        int c;
        value = 7'd12;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        value = 7'd58;
        wait_done(c);
        chk("mid_first_bcd", {24'd0, bcd_tens, bcd_units}, 32'h12);
        wait_done(c);
        chk("mid_restart_gap", c, 32'd10);
        chk("mid_second_bcd", {24'd0, bcd_tens, bcd_units}, 32'h58);
    endtask

    task automatic test_out_of_range();
        int c;
        value = 7'd120;
        wait_done(c);
        chk("oor_conv_seen", {31'd0, c != 0}, 32'd1);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("oor_dash", {25'd0, seg}, {25'd0, S_DASH});
            step();
        end
        value = 7'd20;
        wait_done(c);
        chk("back_bcd", {24'd0, bcd_tens, bcd_units}, 32'h20);
        step();
        for (int i = 0; i < 8; i++) begin
            if (an == 2'b10) chk("back_units", {25'd0, seg}, {25'd0, S_0});
            else chk("back_tens", {25'd0, seg}, {25'd0, S_2});
            step();
        end
    endtask

    task automatic test_reset_mid_conv();
        int c;
        value = 7'd77;
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("abort_bcd", {24'd0, bcd_tens, bcd_units}, 32'h00);
        chk("abort_an", {30'd0, an}, 32'h3);
        rst = 1'b0;
        wait_done(c);
        chk("abort_reconv_latency", c, 32'd9);
        chk("abort_reconv_bcd", {24'd0, bcd_tens, bcd_units}, 32'h77);
    endtask

    task automatic test_blink();
        int run;
        int changes = 0;
        logic lit;
        logic prev;
        step(); step(); step(); step();
        blink = 1'b1;
        step();
        prev = (an != 2'b11);
        run = 0;
        for (int i = 0; i < 48; i++) begin
            lit = (an != 2'b11);
            if (!lit) chk("blink_dark_seg", {25'd0, seg}, {25'd0, S_OFF});
            if (lit == prev) begin
                run++;
            end else begin
                if (changes > 0) chk("blink_period", run, 32'd8);
                changes++;
                run = 1;
                prev = lit;
            end
            step();
        end
        chk("blink_toggled", {31'd0, changes >= 4}, 32'd1);
        blink = 1'b0;
        step();
        changes = 0;
        for (int i = 0; i < 16; i++) begin
            if (an == 2'b11) changes++;
            step();
        end
        chk("noblink_always_lit", changes, 32'd0);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_scan();
        test_mid_change();
        test_out_of_range();
        test_reset_mid_conv();
        test_blink();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
